// File: rtl/action_tbl_ctrl_if.sv
// Action table controller bus: host and learning-engine write requesters,
// bulk-clear control, and the registered write port toward the table.
interface action_tbl_ctrl_if #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned ACTION_W = 64
);
  localparam int unsigned AW = $clog2(ENTRIES);

  logic                a_req;
  logic                a_default;
  logic [AW-1:0]       a_addr;
  logic [ACTION_W-1:0] a_data;
  logic                a_gnt;

  logic                b_req;
  logic [AW-1:0]       b_addr;
  logic [ACTION_W-1:0] b_data;
  logic                b_gnt;

  logic                clr_start;
  logic [ACTION_W-1:0] clr_data;
  logic                clr_busy;
  logic                clr_done;

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [ACTION_W-1:0] wr_data;
  logic                wr_default;
  logic [ACTION_W-1:0] default_data;
  logic [15:0]         wr_count;

  modport master (
    output a_req, a_default, a_addr, a_data,
    output b_req, b_addr, b_data,
    output clr_start, clr_data,
    input  a_gnt, b_gnt, clr_busy, clr_done,
    input  wr_en, wr_addr, wr_data, wr_default, default_data, wr_count
  );

  modport slave (
    input  a_req, a_default, a_addr, a_data,
    input  b_req, b_addr, b_data,
    input  clr_start, clr_data,
    output a_gnt, b_gnt, clr_busy, clr_done,
    output wr_en, wr_addr, wr_data, wr_default, default_data, wr_count
  );
endinterface

// File: rtl/action_tbl_ctrl.sv
// Action table write controller: round-robin arbitration of host/learning
// writes into a one-cycle-latency write port, plus a sequential bulk clear.
module action_tbl_ctrl #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned ACTION_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  action_tbl_ctrl_if.slave  bus
);
  localparam int unsigned AW = $clog2(ENTRIES);
  localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prio_b;
  logic [AW-1:0]       r_idx;
  logic [ACTION_W-1:0] r_clr_data;

  logic                r_wr_en;
  logic                r_wr_default;
  logic [AW-1:0]       r_wr_addr;
  logic [ACTION_W-1:0] r_wr_data;
  logic [ACTION_W-1:0] r_default_data;
  logic                r_clr_done;
  logic [15:0]         r_wr_count;

  logic                w_a_gnt;
  logic                w_b_gnt;
  logic                w_clr_accept;
  logic                w_wr_en;
  logic                w_wr_default;
  logic [AW-1:0]       w_wr_addr;
  logic [ACTION_W-1:0] w_wr_data;
  logic [ACTION_W-1:0] w_default_data;
  logic                w_clr_done;
  logic [AW-1:0]       w_idx_inc;

  assign w_idx_inc = r_idx + AW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.clr_start)       w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_idx == LAST_IDX)   w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // Grants and next values of the registered write port; r_idx is the clear
  // index currently presented on the port, so the step decided here is r_idx+1.
  always_comb begin
    w_a_gnt        = 1'b0;
    w_b_gnt        = 1'b0;
    w_clr_accept   = 1'b0;
    w_wr_en        = 1'b0;
    w_wr_default   = 1'b0;
    w_wr_addr      = r_wr_addr;
    w_wr_data      = r_wr_data;
    w_default_data = r_default_data;
    w_clr_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_start) begin
          w_clr_accept = 1'b1;
          w_wr_en      = 1'b1;
          w_wr_addr    = '0;
          w_wr_data    = bus.clr_data;
        end else if (bus.a_req && (!bus.b_req || !r_prio_b)) begin
          w_a_gnt = 1'b1;
          if (bus.a_default) begin
            w_wr_default   = 1'b1;
            w_default_data = bus.a_data;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_addr = bus.a_addr;
            w_wr_data = bus.a_data;
          end
        end else if (bus.b_req) begin
          w_b_gnt   = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_addr = bus.b_addr;
          w_wr_data = bus.b_data;
        end
      end
      S_CLEAR: begin
        if (r_idx != LAST_IDX) begin
          w_wr_en    = 1'b1;
          w_wr_addr  = w_idx_inc;
          w_wr_data  = r_clr_data;
          w_clr_done = (w_idx_inc == LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio_b       <= 1'b0;
      r_idx          <= '0;
      r_clr_data     <= '0;
      r_wr_en        <= 1'b0;
      r_wr_default   <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_default_data <= '0;
      r_clr_done     <= 1'b0;
      r_wr_count     <= '0;
    end else begin
      if (w_a_gnt)      r_prio_b <= 1'b1;
      else if (w_b_gnt) r_prio_b <= 1'b0;

      if (w_clr_accept) begin
        r_idx      <= '0;
        r_clr_data <= bus.clr_data;
      end else if (r_state == S_CLEAR && r_idx != LAST_IDX) begin
        r_idx <= w_idx_inc;
      end

      r_wr_en        <= w_wr_en;
      r_wr_default   <= w_wr_default;
      r_wr_addr      <= w_wr_addr;
      r_wr_data      <= w_wr_data;
      r_default_data <= w_default_data;
      r_clr_done     <= w_clr_done;

      if ((w_wr_en || w_wr_default) && r_wr_count != 16'hFFFF)
        r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign bus.a_gnt        = w_a_gnt & rst_n;
  assign bus.b_gnt        = w_b_gnt & rst_n;
  assign bus.clr_busy     = (r_state == S_CLEAR);
  assign bus.clr_done     = r_clr_done;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.wr_default   = r_wr_default;
  assign bus.default_data = r_default_data;
  assign bus.wr_count     = r_wr_count;
endmodule

// File: doc/action_tbl_ctrl.md
ACTION_TBL_CTRL -- requirements
Module: action_tbl_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of action table entries, a power of two >= 2.
REQ-002 SHALL have parameter ACTION_W, default 64: action word width.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have ports a_req (in, 1), a_default (in, 1; 1 selects a default-action write), a_addr (in, AW = log2(ENTRIES)), a_data (in, ACTION_W), a_gnt (out, 1): host config requester.
REQ-006 SHALL have ports b_req (in, 1), b_addr (in, AW), b_data (in, ACTION_W), b_gnt (out, 1): learning-engine requester, entry writes only.
REQ-007 SHALL have ports clr_start (in, 1), clr_data (in, ACTION_W), clr_busy (out, 1), clr_done (out, 1): bulk table clear.
REQ-008 SHALL have ports wr_en (out, 1), wr_addr (out, AW), wr_data (out, ACTION_W), wr_default (out, 1), default_data (out, ACTION_W): write port to the action table.
REQ-009 SHALL have port wr_count, output, 16: count of issued writes.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-011 In IDLE, a_gnt and b_gnt SHALL be combinational, asserted in the cycle a request is accepted; at most one grant per cycle.
REQ-012 A requester SHALL hold req and its payload until it sees gnt; a grant consumes exactly one request.
REQ-013 If only one of a_req or b_req is high in IDLE without clr_start, that requester SHALL be granted.
REQ-014 If a_req and b_req are both high, the grant SHALL alternate round-robin using a last-grant pointer; after reset A wins first.
REQ-015 The pointer SHALL update only on a grant.
REQ-016 A grant SHALL produce registered outputs on the next cycle, a one-cycle write latency.
- A entry write: wr_en=1, wr_addr=a_addr, wr_data=a_data.
- A default write (a_default=1): wr_default=1, default_data=a_data, wr_en=0.
- B write: wr_en=1, wr_addr=b_addr, wr_data=b_data.
REQ-017 wr_en and wr_default SHALL be single-cycle pulses, low in any cycle without a corresponding grant or clear step.
REQ-018 wr_addr, wr_data and default_data SHALL hold their last values when not writing.
REQ-019 clr_start sampled high in IDLE SHALL move the FSM to CLEAR with index 0, and SHALL take priority over any same-cycle request (no grant that cycle).
REQ-020 clr_data SHALL be captured when clr_start is accepted.
REQ-021 In CLEAR, the block SHALL issue one wr_en per cycle to indices 0..ENTRIES-1 in order with the captured data, ENTRIES consecutive cycles, the first in the cycle after acceptance.
REQ-022 clr_busy SHALL be high in every CLEAR cycle.
REQ-023 a_gnt and b_gnt SHALL be 0 in CLEAR.
REQ-024 clr_start SHALL be ignored while in CLEAR.
REQ-025 clr_done SHALL pulse for one cycle, coincident with the write to index ENTRIES-1; the FSM SHALL then return to IDLE and may grant in the following cycle.
REQ-026 A clear SHALL NOT write the default action.
REQ-027 wr_count SHALL increment by 1 per cycle with wr_en or wr_default high, including clear writes, and SHALL saturate at 16'hFFFF.

Reset
REQ-028 With rst_n low at a clock edge, the block SHALL reset to: FSM IDLE, pointer favouring A, clear index 0, and all outputs (including wr_addr, wr_data, default_data and wr_count) 0.
REQ-029 While rst_n is low, a_gnt and b_gnt SHALL be forced 0.
REQ-030 Reset during CLEAR SHALL abort the clear with no clr_done pulse and no further writes.

Verification
REQ-031 Bench SHALL cover: a_req with a_addr=3, a_data=64'hAA held -> a_gnt in cycle 0; wr_en=1, wr_addr=3, wr_data=64'hAA in cycle 1; wr_count=1.
REQ-032 Bench SHALL cover: a_req and b_req held high for 4 cycles -> grants A, B, A, B and 4 writes in that order.
REQ-033 Bench SHALL cover: a_req with a_default=1, a_data=64'h55 -> wr_default=1, default_data=64'h55, wr_en=0 one cycle after a_gnt.
REQ-034 Bench SHALL cover: clr_start with clr_data=0 plus a simultaneous b_req, ENTRIES=16 -> no b_gnt; 16 writes to addresses 0..15; clr_busy high for 16 cycles; clr_done with address 15; b_gnt in the cycle after.
REQ-035 Bench SHALL cover: rst_n low at clear step 5 -> no writes after reset, clr_done never pulses, all outputs 0, FSM in IDLE.
REQ-036 Bench SHALL cover: wr_count preloaded to 16'hFFFE by 65534 writes, then 3 more writes -> wr_count holds 16'hFFFF.
